bmc_tx_scheduler: RTL and testbench
===================================

Name: bmc_tx_scheduler

Overview:
Frame sequencer that sits in front of the biphase-mark (BMC) transmitter encoder on fpga1. It accepts parallel payload words over a valid/ready handshake and builds S/PDIF-style subframes: an 8-cell raw preamble, then DATA_W payload bits, then an even-parity bit. For each half-bit cell it drives the encoder's logical bit, phase and encode/raw select, on a fixed cell timebase. It alternates channels A/B and inserts a Z preamble at the start of each block.

Parameters:
DATA_W, 24, payload bits per subframe (>=1), sent LSB first
CELL_DIV, 4, clk cycles per half-bit cell (>=1)
BLOCK_LEN, 192, frames per block; each frame is an A subframe followed by a B subframe

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
en  in  1  run enable; deassertion finishes the current subframe and then idles
din  in  DATA_W  payload word
din_valid  in  1  payload valid
din_ready  out  1  scheduler accepts din this cycle
line_in  in  1  current encoder output line level, used for preamble polarity
enc_bit  out  1  logical bit to the encoder (the raw level during a preamble)
enc_phase  out  1  0 = first half-cell, 1 = second half-cell
enc_bmc  out  1  1 = encoder BMC-encodes enc_bit; 0 = encoder passes enc_bit raw
enc_valid  out  1  one-cycle strobe at the first clk of each half-cell
sf_start  out  1  one-cycle pulse with the first preamble strobe of each subframe
blk_start  out  1  one-cycle pulse with sf_start when the preamble is Z
underrun  out  1  one-cycle pulse when a subframe starts with no word available

Behaviour:
- Reset values: all outputs 0; state IDLE; channel A; frame count 0; cell timer 0.
- State IDLE: din_ready = en.
  - On din_valid & din_ready: latch din, compute even parity (XOR of all payload bits), go to PRE.
  - The first enc_valid strobe is on the next cycle. Latency is 1 cycle.
- Cell timer:
  - Counts 0..CELL_DIV-1 while not in IDLE, and wraps.
  - enc_valid = 1 when the count is 0. All enc_* outputs are registered and held for the whole half-cell.
- State PRE: 8 half-cells.
  - Pattern selection: Z if channel A and frame count is 0; X if channel A otherwise; Y if channel B.
  - Polarity variant is chosen by line_in, sampled on the cycle the subframe is entered: variant 0 if line_in = 0, variant 1 if line_in = 1.
  - Patterns, MSB sent first: Z0 11101000, Z1 00010111, X0 11100010, X1 00011101, Y0 11100100, Y1 00011011.
  - enc_bmc = 0. enc_phase toggles each half-cell, starting at 0.
- State DATA: DATA_W bits, LSB first, 2 half-cells each. enc_bit is held for both halves; enc_phase = 0 then 1; enc_bmc = 1.
- State PAR: 1 parity bit, with the same 2-half-cell format as DATA.
- Subframe length: 8 + 2*(DATA_W+1) half-cells, i.e. (8 + 2*(DATA_W+1)) * CELL_DIV clk cycles.
- End of subframe (last cycle of the PAR second half):
  - din_ready = en.
  - If en & din_valid: latch the word and start the next subframe with no gap.
  - If en & !din_valid: send payload 0 (parity 0), pulse underrun, continue with no gap.
  - If !en: go to IDLE; the channel and frame count are preserved.
- Counters:
  - Channel toggles A→B→A at each subframe end.
  - Frame count increments after each B subframe and wraps from BLOCK_LEN-1 to 0.
- din_ready is 0 at all other times. din is never sampled outside an asserted din_ready.
- rst mid-subframe: immediate return to reset values. The partial subframe is discarded; enc_valid is 0 on the next cycle.
- Simultaneous underrun and block start: both pulses are asserted, and the Z preamble is still sent.

Decomposition:
- Package bmc_pkg holds:
  - state enum {IDLE, PRE, DATA, PAR}
  - channel enum {CH_A, CH_B}
  - the six 8-bit preamble constants
  - PRE_CELLS = 8
- One sub-module, bmc_cell_timer (CELL_DIV counter, outputs the tick strobe and a last-cycle flag), which is reusable by the receiver.

Test Plan:
1. Reset defaults. DATA_W=4, CELL_DIV=1, BLOCK_LEN=2, line_in=0, din=4'b0101 valid in IDLE.
   Required: ready in cycle 0; enc_bit over half-cells 0-7 is 11101000 (Z0) with enc_bmc=0; then bits 1,1,0,0,1,1,0,0, parity 0,0 with enc_bmc=1; sf_start and blk_start at cycle 1; 18 strobes in total.
2. Polarity. As scenario 1 with line_in=1 at subframe entry. Required: preamble 00010111 (Z1).
3. Sequencing. Stream 4 words back-to-back. Required: preambles Z, Y, X, Y; blk_start only on subframe 0; no gap cycles between subframes.
4. Underrun. din_valid=0 at the end of subframe 1. Required: underrun pulses once; the next subframe carries payload 0000 and parity 0; streaming continues.
5. Timing. CELL_DIV=3, DATA_W=4. Required: each half-cell lasts 3 cycles; enc_valid fires at counts 0, 3, 6, …; subframe length is 54 cycles.
6. Control. Drop en mid-subframe: the subframe completes and the block goes to IDLE with din_ready=0. Then assert rst mid-subframe: all outputs are 0 the next cycle, and the next start uses a Z preamble.

Source files
------------

// File: rtl/bmc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bmc_pkg
//  Description : Shared types and constants for the BMC transmit path.
//                Holds the scheduler state encoding, channel encoding, the
//                six S/PDIF-style preamble patterns (MSB sent first) and a
//                helper that picks the pattern for a subframe.
//  Revision    : 1.0 - initial release
// ============================================================================
package bmc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        PAR  = 2'd3
    } state_t;

    typedef enum logic {
        CH_A = 1'b0,
        CH_B = 1'b1
    } chan_t;

    localparam int PRE_CELLS = 8;

    // Variant 0 is used when the line currently sits low, variant 1 when high.
    localparam logic [7:0] c_PRE_Z0 = 8'b1110_1000;
    localparam logic [7:0] c_PRE_Z1 = 8'b0001_0111;
    localparam logic [7:0] c_PRE_X0 = 8'b1110_0010;
    localparam logic [7:0] c_PRE_X1 = 8'b0001_1101;
    localparam logic [7:0] c_PRE_Y0 = 8'b1110_0100;
    localparam logic [7:0] c_PRE_Y1 = 8'b0001_1011;

    // Z marks the A subframe of the first frame in a block, X any other
    // A subframe, Y every B subframe.
    function automatic logic [7:0] pre_select(input chan_t ch,
                                              input logic  first_frame,
                                              input logic  pol);
        logic [7:0] pat;
        if (ch == CH_B) begin
            pat = pol ? c_PRE_Y1 : c_PRE_Y0;
        end else if (first_frame) begin
            pat = pol ? c_PRE_Z1 : c_PRE_Z0;
        end else begin
            pat = pol ? c_PRE_X1 : c_PRE_X0;
        end
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bmc_tx_scheduler_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bmc_cell_timer
//  Description : Half-cell timebase. Counts 0..CELL_DIV-1 while i_run is
//                high and wraps; held at 0 otherwise.
//  Ports       : clk, rst   - clock, synchronous active-high reset
//                i_run      - count enable (counter forced to 0 when low)
//                o_tick     - first cycle of a half-cell (count == 0)
//                o_last     - last cycle of a half-cell (count == CELL_DIV-1)
//  Revision    : 1.0 - initial release
// ============================================================================
module bmc_cell_timer #(
    parameter int CELL_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_run,
    output logic o_tick,
    output logic o_last
);

    localparam int              CNT_W     = (CELL_DIV > 1) ? $clog2(CELL_DIV) : 1;
    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(CELL_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_run || (r_cnt == c_CNT_MAX)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_run && (r_cnt == '0);
    assign o_last = i_run && (r_cnt == c_CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/bmc_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : bmc_tx_scheduler
//  Description : Subframe sequencer in front of the BMC encoder. Accepts
//                payload words over valid/ready and emits, one half-cell at a
//                time, an 8-cell raw preamble, DATA_W payload bits (LSB first,
//                two half-cells each) and an even-parity bit. Alternates
//                channels A/B and inserts a Z preamble at each block start.
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                en                  - run enable (stops after current subframe)
//                din/din_valid/din_ready - payload handshake
//                line_in             - encoder line level, picks preamble polarity
//                enc_bit/enc_phase/enc_bmc/enc_valid - per-half-cell encoder control
//                sf_start/blk_start/underrun - subframe event pulses
//  Revision    : 1.0 - initial release
// ============================================================================
module bmc_tx_scheduler
    import bmc_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int CELL_DIV  = 4,
    parameter int BLOCK_LEN = 192
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic              line_in,
    output logic              enc_bit,
    output logic              enc_phase,
    output logic              enc_bmc,
    output logic              enc_valid,
    output logic              sf_start,
    output logic              blk_start,
    output logic              underrun
);

    localparam int IDX_SPAN = (2 * DATA_W > PRE_CELLS) ? 2 * DATA_W : PRE_CELLS;
    localparam int IDX_W    = $clog2(IDX_SPAN);
    localparam int FRM_W    = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

    localparam logic [IDX_W-1:0] c_IDX_PRE_LAST  = IDX_W'(PRE_CELLS - 1);
    localparam logic [IDX_W-1:0] c_IDX_DATA_LAST = IDX_W'(2 * DATA_W - 1);
    localparam logic [IDX_W-1:0] c_IDX_ONE       = IDX_W'(1);
    localparam logic [FRM_W-1:0] c_FRM_LAST      = FRM_W'(BLOCK_LEN - 1);

    state_t             r_state;
    chan_t              r_chan;
    logic [FRM_W-1:0]   r_frame;
    logic [IDX_W-1:0]   r_idx;      // half-cell index within the current state
    logic [7:0]         r_pat;      // preamble, shifted left as cells go out
    logic [DATA_W-1:0]  r_data;     // payload, shifted right per finished bit
    logic               r_par;
    logic               r_enc_bit;
    logic               r_enc_phase;
    logic               r_enc_bmc;
    logic               r_enc_valid;
    logic               r_sf_start;
    logic               r_blk_start;
    logic               r_underrun;

    logic               w_tick;
    logic               w_last;
    logic               w_sf_end;
    logic               w_ready;
    logic               w_take;
    logic               w_start;
    chan_t              w_chan_nx;
    logic [FRM_W-1:0]   w_frame_nx;
    chan_t              w_start_chan;
    logic [FRM_W-1:0]   w_start_frame;
    logic [7:0]         w_start_pat;
    logic [DATA_W-1:0]  w_start_word;
    logic               w_start_par;
    logic [DATA_W-1:0]  w_shift;

    bmc_cell_timer #(
        .CELL_DIV (CELL_DIV)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .i_run  (r_state != IDLE),
        .o_tick (w_tick),
        .o_last (w_last)
    );

    // Final cycle of the parity bit's second half: the only in-flight point
    // where a new word may be taken.
    assign w_sf_end = (r_state == PAR) && (r_idx == c_IDX_ONE) && w_last;
    assign w_ready  = !rst && en && ((r_state == IDLE) || w_sf_end);
    assign w_take   = w_ready && din_valid;
    // From IDLE only a real word starts a subframe; back-to-back an empty
    // slot is filled with a zero payload instead of leaving a gap.
    assign w_start  = w_take || (w_sf_end && en);

    assign w_chan_nx  = (r_chan == CH_A) ? CH_B : CH_A;
    assign w_frame_nx = (r_chan == CH_B) ? ((r_frame == c_FRM_LAST) ? '0 : r_frame + 1'b1)
                                         : r_frame;

    // A subframe launched at a subframe end belongs to the advanced counters.
    assign w_start_chan  = (r_state == IDLE) ? r_chan  : w_chan_nx;
    assign w_start_frame = (r_state == IDLE) ? r_frame : w_frame_nx;
    assign w_start_pat   = pre_select(w_start_chan, (w_start_frame == '0), line_in);
    assign w_start_word  = w_take ? din : '0;
    assign w_start_par   = w_take ? ^din : 1'b0;
    assign w_shift       = r_data >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_chan      <= CH_A;
            r_frame     <= '0;
            r_idx       <= '0;
            r_pat       <= '0;
            r_data      <= '0;
            r_par       <= 1'b0;
            r_enc_bit   <= 1'b0;
            r_enc_phase <= 1'b0;
            r_enc_bmc   <= 1'b0;
            r_enc_valid <= 1'b0;
            r_sf_start  <= 1'b0;
            r_blk_start <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_sf_start  <= 1'b0;
            r_blk_start <= 1'b0;
            r_underrun  <= 1'b0;

            if (w_start) begin
                if (w_sf_end) begin
                    r_chan  <= w_chan_nx;
                    r_frame <= w_frame_nx;
                end
                r_state     <= PRE;
                r_idx       <= '0;
                r_pat       <= w_start_pat;
                r_data      <= w_start_word;
                r_par       <= w_start_par;
                r_enc_bit   <= w_start_pat[7];
                r_enc_phase <= 1'b0;
                r_enc_bmc   <= 1'b0;
                r_enc_valid <= 1'b1;
                r_sf_start  <= 1'b1;
                r_blk_start <= (w_start_chan == CH_A) && (w_start_frame == '0);
                r_underrun  <= !w_take;
            end else if (w_sf_end) begin
                // Enable dropped: stop cleanly, keep channel/frame position.
                r_chan      <= w_chan_nx;
                r_frame     <= w_frame_nx;
                r_state     <= IDLE;
                r_idx       <= '0;
                r_enc_bit   <= 1'b0;
                r_enc_phase <= 1'b0;
                r_enc_bmc   <= 1'b0;
                r_enc_valid <= 1'b0;
            end else if (w_last) begin
                r_enc_valid <= 1'b1;
                case (r_state)
                    PRE: begin
                        if (r_idx == c_IDX_PRE_LAST) begin
                            r_state     <= DATA;
                            r_idx       <= '0;
                            r_enc_bit   <= r_data[0];
                            r_enc_phase <= 1'b0;
                            r_enc_bmc   <= 1'b1;
                        end else begin
                            r_idx       <= r_idx + 1'b1;
                            r_pat       <= r_pat << 1;
                            r_enc_bit   <= r_pat[6];
                            r_enc_phase <= ~r_enc_phase;
                        end
                    end
                    DATA: begin
                        if (r_idx == c_IDX_DATA_LAST) begin
                            r_state     <= PAR;
                            r_idx       <= '0;
                            r_enc_bit   <= r_par;
                            r_enc_phase <= 1'b0;
                        end else begin
                            r_idx       <= r_idx + 1'b1;
                            r_enc_phase <= ~r_enc_phase;
                            // Move to the next payload bit only after its second half.
                            if (r_enc_phase) begin
                                r_data    <= w_shift;
                                r_enc_bit <= w_shift[0];
                            end
                        end
                    end
                    PAR: begin
                        r_idx       <= r_idx + 1'b1;
                        r_enc_phase <= 1'b1;
                    end
                    default: begin
                    end
                endcase
            end else if (w_tick) begin
                r_enc_valid <= 1'b0;
            end
        end
    end

    assign din_ready = w_ready;
    assign enc_bit   = r_enc_bit;
    assign enc_phase = r_enc_phase;
    assign enc_bmc   = r_enc_bmc;
    assign enc_valid = r_enc_valid;
    assign sf_start  = r_sf_start;
    assign blk_start = r_blk_start;
    assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_bmc_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_bmc_tx_scheduler
//  Description : Self-checking bench for bmc_tx_scheduler. Two instances
//                (CELL_DIV=1 and CELL_DIV=3, DATA_W=4, BLOCK_LEN=2) share the
//                stimulus; a subframe-level reference model predicts every
//                half-cell from the payload, channel, frame and line level.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bmc_tx_scheduler;

    localparam int DW = 4;
    localparam int BL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          line_in = 1'b0;

    logic d1_ready, d1_bit, d1_phase, d1_bmc, d1_valid, d1_sf, d1_blk, d1_ur;
    logic d3_ready, d3_bit, d3_phase, d3_bmc, d3_valid, d3_sf, d3_blk, d3_ur;

    always #5 clk = ~clk;

    bmc_tx_scheduler #(.DATA_W(DW), .CELL_DIV(1), .BLOCK_LEN(BL)) dut1 (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(d1_ready), .line_in(line_in), .enc_bit(d1_bit),
        .enc_phase(d1_phase), .enc_bmc(d1_bmc), .enc_valid(d1_valid),
        .sf_start(d1_sf), .blk_start(d1_blk), .underrun(d1_ur)
    );

    bmc_tx_scheduler #(.DATA_W(DW), .CELL_DIV(3), .BLOCK_LEN(BL)) dut3 (
        .clk(clk), .rst(rst), .en(en), .din(din), .din_valid(din_valid),
        .din_ready(d3_ready), .line_in(line_in), .enc_bit(d3_bit),
        .enc_phase(d3_phase), .enc_bmc(d3_bmc), .enc_valid(d3_valid),
        .sf_start(d3_sf), .blk_start(d3_blk), .underrun(d3_ur)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit sel3     = 1'b0;   // which instance is under observation

    // Reference model position
    bit m_chan_b = 1'b0;
    int m_frame  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {ready, bit, phase, bmc, valid, sf_start, blk_start, underrun}
    function automatic logic [7:0] outs();
        if (sel3)
            return {d3_ready, d3_bit, d3_phase, d3_bmc, d3_valid, d3_sf, d3_blk, d3_ur};
        return {d1_ready, d1_bit, d1_phase, d1_bmc, d1_valid, d1_sf, d1_blk, d1_ur};
    endfunction

    function automatic logic [7:0] exp_pattern(input bit chan_b, input int frame, input bit li);
        if (chan_b)      return li ? 8'b00011011 : 8'b11100100;   // Y
        if (frame == 0)  return li ? 8'b00010111 : 8'b11101000;   // Z
        return li ? 8'b00011101 : 8'b11100010;                    // X
    endfunction

    task automatic present(input bit en_v, input bit valid_v, input logic [DW-1:0] w, input bit li);
        en        = en_v;
        din_valid = valid_v;
        din       = w;
        line_in   = li;
    endtask

    task automatic model_reset();
        m_chan_b = 1'b0;
        m_frame  = 0;
    endtask

    // Checks one whole subframe cycle by cycle. drop_at/abort_at (cycle
    // index, -1 = never) drop en or raise rst after that cycle's checks.
    task automatic check_sf(input logic [DW-1:0] w, input bit li, input bit uf,
                            input int drop_at, input int abort_at);
        int         cd    = sel3 ? 3 : 1;
        int         total = 18 * cd;
        logic [7:0] pat   = exp_pattern(m_chan_b, m_frame, li);
        bit         blk   = !m_chan_b && (m_frame == 0);
        bit         par   = ^w;
        logic [7:0] o;
        for (int c = 0; c < total; c++) begin
            int k = c / cd;
            bit e_bit, e_ph, e_bmc;
            if (k < 8) begin
                e_bit = pat[7-k]; e_ph = k[0]; e_bmc = 1'b0;
            end else if (k < 16) begin
                e_bit = w[(k-8)/2]; e_ph = k[0]; e_bmc = 1'b1;
            end else begin
                e_bit = par; e_ph = (k == 17); e_bmc = 1'b1;
            end
            @(negedge clk);
            o = outs();
            chk($sformatf("enc_valid c=%0d", c), o[3], (c % cd) == 0);
            chk($sformatf("enc_bit c=%0d", c),   o[6], e_bit);
            chk($sformatf("enc_phase c=%0d", c), o[5], e_ph);
            chk($sformatf("enc_bmc c=%0d", c),   o[4], e_bmc);
            chk($sformatf("sf_start c=%0d", c),  o[2], c == 0);
            chk($sformatf("blk_start c=%0d", c), o[1], (c == 0) && blk);
            chk($sformatf("underrun c=%0d", c),  o[0], (c == 0) && uf);
            chk($sformatf("din_ready c=%0d", c), o[7], (c == total - 1) && en);
            if (c == 0) begin
                din_valid = 1'b0;
                din       = DW'($urandom);
                line_in   = $urandom_range(0, 1) == 1;
            end
            if (c == drop_at) en = 1'b0;
            if (c == abort_at) begin
                rst = 1'b1;
                return;
            end
        end
        if (m_chan_b) m_frame = (m_frame + 1) % BL;
        m_chan_b = !m_chan_b;
    endtask

    task automatic idle_chk(input string tag);
        logic [7:0] o;
        @(negedge clk);
        o = outs();
        chk({tag, " outputs"}, {24'd0, o[6:0]}, 32'd0);
        chk({tag, " din_ready"}, o[7], en && !rst);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        present(1'b0, 1'b0, '0, 1'b0);
        idle_chk("reset");
        rst = 1'b0;
        model_reset();
    endtask

    task automatic start_chk(input logic [DW-1:0] w, input bit li);
        present(1'b1, 1'b1, w, li);
        #1;
        chk("idle din_ready", outs() >> 7, 32'd1);
    endtask

    initial begin
        logic [DW-1:0] w;
        bit            li;
        bit            uf;

        // Reset defaults on both instances
        repeat (2) @(negedge clk);
        sel3 = 1'b1;
        idle_chk("reset d3");
        sel3 = 1'b0;
        do_reset();

        // Basic subframe: Z0 preamble, payload 0101, parity 0
        start_chk(4'b0101, 1'b0);
        check_sf(4'b0101, 1'b0, 1'b0, -1, -1);
        present(1'b0, 1'b0, '0, 1'b0);
        idle_chk("stop after sf");

        // Polarity: same word, line high at entry
        do_reset();
        start_chk(4'b0101, 1'b1);
        check_sf(4'b0101, 1'b1, 1'b0, -1, -1);

        // Back-to-back stream Y, X, Y
        for (int i = 0; i < 3; i++) begin
            w  = DW'($urandom);
            li = $urandom_range(0, 1) == 1;
            present(1'b1, 1'b1, w, li);
            check_sf(w, li, 1'b0, -1, -1);
        end

        // Underrun coinciding with block start (next subframe is Z)
        li = $urandom_range(0, 1) == 1;
        present(1'b1, 1'b0, DW'($urandom), li);
        check_sf('0, li, 1'b1, -1, -1);

        // Randomised streaming with occasional underruns
        for (int i = 0; i < 10; i++) begin
            uf = $urandom_range(0, 3) == 0;
            w  = uf ? '0 : DW'($urandom);
            li = $urandom_range(0, 1) == 1;
            present(1'b1, !uf, uf ? DW'($urandom) : w, li);
            check_sf(w, li, uf, -1, -1);
        end

        // Drop en mid-subframe: it completes, then idles
        w  = DW'($urandom);
        li = $urandom_range(0, 1) == 1;
        present(1'b1, 1'b1, w, li);
        check_sf(w, li, 1'b0, 5, -1);
        present(1'b0, 1'b1, DW'($urandom), 1'b0);
        idle_chk("en drop idle");
        idle_chk("en drop idle2");

        // Restart resumes the preserved channel/frame position
        w  = DW'($urandom);
        li = $urandom_range(0, 1) == 1;
        start_chk(w, li);
        check_sf(w, li, 1'b0, -1, -1);

        // Reset mid-subframe
        w  = DW'($urandom);
        present(1'b1, 1'b1, w, 1'b0);
        check_sf(w, 1'b0, 1'b0, -1, 7);
        present(1'b1, 1'b0, '0, 1'b0);
        idle_chk("mid reset");
        rst = 1'b0;
        model_reset();
        w  = DW'($urandom);
        li = $urandom_range(0, 1) == 1;
        start_chk(w, li);
        check_sf(w, li, 1'b0, -1, -1);

        // Timing on the CELL_DIV=3 instance: 54-cycle subframes, no gap
        sel3 = 1'b1;
        do_reset();
        w  = DW'($urandom);
        li = $urandom_range(0, 1) == 1;
        start_chk(w, li);
        check_sf(w, li, 1'b0, -1, -1);
        w  = DW'($urandom);
        li = $urandom_range(0, 1) == 1;
        present(1'b1, 1'b1, w, li);
        check_sf(w, li, 1'b0, -1, -1);
        present(1'b0, 1'b0, '0, 1'b0);
        idle_chk("d3 stop");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
